// File: rtl/sram_burst_ctrl.sv
// Burst controller turning one address/length command into consecutive SRAM beats.
// Latency: write beats go to the SRAM on their own handshake edge; read beat 0 appears 2 cycles after accept.
// Backpressure: cmd_ready only in IDLE; wr_valid low stalls a write burst; read data has no backpressure.
//
// Ports:
//   clk, rst_n                 single clock, synchronous active-low reset
//   cmd_valid/ready/wr/addr/len burst command (len = beats - 1)
//   wr_data/valid/ready        write beat stream
//   rd_data/valid              read beat stream (rd_data is sram_dout passed straight through)
//   busy                       high whenever a burst is in progress
//   sram_we_n/addr/din/dout    single-port synchronous SRAM with a registered read port
module sram_burst_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_DEPTH = 16,  // must be 2**ADDR_WIDTH
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  sram_we_n,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_din,
  input  logic [WORD_WIDTH-1:0] sram_dout
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic                  we_n_fsm;

  // Explicit wrap keeps the modulo-depth intent visible even though the
  // natural binary overflow gives the same result for a power-of-two depth.
  assign addr_inc = (cur_addr_q == ADDR_WIDTH'(WORD_DEPTH - 1)) ? '0 : cur_addr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    we_n_fsm   = 1'b1;
    busy       = 1'b1;
    // The SRAM registers its output one edge after the address, so the
    // beat addressed during READ is valid in the following cycle.
    rd_valid_d = (state_q == READ);
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d = cmd_addr;
          rem_d      = cmd_len;
          state_d    = cmd_wr ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        we_n_fsm = !wr_valid;
        if (wr_valid) begin
          cur_addr_d = addr_inc;
          rem_d      = rem_q - 1'b1;
          if (rem_q == '0) state_d = IDLE;
        end
      end
      READ: begin
        cur_addr_d = addr_inc;
        rem_d      = rem_q - 1'b1;
        if (rem_q == '0) state_d = DRAIN;
      end
      // One cycle to let the last registered read word out.
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset forces the write strobe off combinationally so no write can
  // land even before the first reset edge, when the state is unknown.
  assign sram_we_n = !rst_n | we_n_fsm;
  assign sram_addr = cur_addr_q;
  assign sram_din  = wr_data;
  assign rd_data   = sram_dout;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_sram_burst_ctrl.sv
module tb_sram_burst_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [3:0] cmd_addr, cmd_len;
  logic [7:0] wr_data;
  logic       wr_valid, wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid, busy;
  logic       sram_we_n;
  logic [3:0] sram_addr;
  logic [7:0] sram_din, sram_dout;

  int n_tests = 0;
  int n_fail  = 0;

  // Environment: synchronous SRAM with registered read data.
  logic [7:0] sram [16];
  // Reference: what the array should hold after each burst.
  logic [7:0] exp_mem [16];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_we_n) sram[sram_addr] <= sram_din;
    sram_dout <= sram[sram_addr];
  end

  sram_burst_ctrl #(.ADDR_WIDTH(4), .WORD_DEPTH(16), .WORD_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .sram_we_n(sram_we_n), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_dout(sram_dout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: wr_valid always high, data A0+beat; mode 1: random gaps and data;
  // mode 2: wr_valid 1,0,1,0,1,1 then high. chain leaves a read of the same
  // range offered on the command port for the whole burst.
  task automatic do_write(input logic [3:0] a, input logic [3:0] l, input int mode, input bit chain);
    int beat = 0;
    int cyc = 0;
    logic wv;
    logic [7:0] d;
    logic [5:0] pat = 6'b110101;
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = a; cmd_len = l;
    #1;
    check("cmd_ready_before_wr", cmd_ready, 1);
    @(negedge clk);
    if (chain) cmd_wr = 1'b0;
    else cmd_valid = 1'b0;
    while (beat <= int'(l) && cyc < 200) begin
      if (mode == 0) wv = 1'b1;
      else if (mode == 2) wv = (cyc < 6) ? pat[cyc] : 1'b1;
      else wv = ($urandom_range(3) != 0);
      d = (mode == 0) ? 8'hA0 + 8'(beat) : 8'($urandom);
      wr_valid = wv; wr_data = d;
      #1;
      check("wr_ready_in_write", wr_ready, 1);
      check("busy_in_write", busy, 1);
      check("cmd_ready_in_write", cmd_ready, 0);
      check("we_n_in_write", sram_we_n, !wv);
      check("addr_in_write", sram_addr, (int'(a) + beat) % 16);
      if (wv) begin
        check("din_in_write", sram_din, d);
        exp_mem[(int'(a) + beat) % 16] = d;
        beat++;
      end
      @(negedge clk);
      cyc++;
    end
    check("write_beats_done", beat, int'(l) + 1);
    wr_valid = 1'b0;
    #1;
    check("busy_after_write", busy, 0);
    check("cmd_ready_after_write", cmd_ready, 1);
    check("wr_ready_after_write", wr_ready, 0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] l);
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = a; cmd_len = l;
    wr_valid = 1'($urandom);
    #1;
    check("cmd_ready_before_rd", cmd_ready, 1);
    check("we_n_idle", sram_we_n, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    check("rd_valid_first_cycle", rd_valid, 0);
    check("busy_rd_first_cycle", busy, 1);
    check("cmd_ready_rd_busy", cmd_ready, 0);
    check("wr_ready_in_read", wr_ready, 0);
    for (int i = 0; i <= int'(l); i++) begin
      @(negedge clk);
      wr_valid = 1'($urandom);
      #1;
      check("rd_valid_beat", rd_valid, 1);
      check("rd_data_beat", rd_data, exp_mem[(int'(a) + i) % 16]);
      check("we_n_in_read", sram_we_n, 1);
      check("busy_in_read", busy, 1);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    check("rd_valid_after_drain", rd_valid, 0);
    check("busy_after_read", busy, 0);
    check("cmd_ready_after_read", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      sram[i] = 8'($urandom);
      exp_mem[i] = sram[i];
    end
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd9; cmd_len = 4'd2;
    wr_valid = 1'b1; wr_data = 8'h55;
    #1;
    check("we_n_before_reset_edge", sram_we_n, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_wr_ready", wr_ready, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_addr", sram_addr, 0);
    check("reset_we_n", sram_we_n, 1);
    cmd_valid = 1'b0; wr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Contiguous write then readback.
    do_write(4'd2, 4'd3, 0, 1'b0);
    do_read(4'd2, 4'd3);

    // Gapped write across the wrap point.
    do_write(4'd14, 4'd3, 2, 1'b0);
    do_read(4'd14, 4'd3);

    // Full-array bursts.
    do_write(4'd7, 4'd15, 1, 1'b0);
    do_read(4'd0, 4'd15);

    // Reset during read beat 2 of an 8-beat burst.
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd4; cmd_len = 4'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rd_beat2_before_reset", rd_data, exp_mem[6]);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rd_valid_after_reset", rd_valid, 0);
    check("busy_after_reset", busy, 0);
    check("cmd_ready_after_reset", cmd_ready, 1);
    @(negedge clk);
    #1;
    check("rd_valid_stays_low", rd_valid, 0);
    do_read(4'd4, 4'd7);

    // Reset during a write: only the beat before the reset edge lands.
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd8; cmd_len = 4'd3;
    @(negedge clk);
    cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'h5A;
    exp_mem[8] = 8'h5A;
    @(negedge clk);
    wr_data = 8'hC3; rst_n = 1'b0;
    #1;
    check("we_n_during_reset", sram_we_n, 1);
    @(negedge clk);
    rst_n = 1'b1; wr_valid = 1'b0;
    #1;
    check("busy_after_wr_reset", busy, 0);
    check("wr_ready_after_wr_reset", wr_ready, 0);
    do_read(4'd8, 4'd3);

    // Command held during a busy write; the read follows in the first IDLE cycle.
    do_write(4'd3, 4'd2, 1, 1'b1);
    do_read(4'd3, 4'd2);

    // Randomized bursts.
    for (int k = 0; k < 20; k++) begin
      logic [3:0] ra, rl;
      ra = 4'($urandom);
      rl = 4'($urandom);
      if ($urandom_range(1) == 1) do_write(ra, rl, 1, 1'b0);
      else do_read(ra, rl);
    end
    do_read(4'd0, 4'd15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
